// File: rtl/equiv_check_if.sv
// Bus between the equivalence-check harness and the environment that hosts
// the reference model and the synthesized netlist.
//
// Handshake: start and seed_load are single-cycle requests sampled on posedge
// clk and honoured only while busy is low; there is no ready/ack, a request
// made while busy is dropped. Results (done, pass, mismatch, fail_idx,
// sig_ref, sig_dut) are valid whenever done is high and stay stable until
// the next accepted start or reset.
interface equiv_check_if #(
    parameter int IN_W  = 68,
    parameter int OUT_W = 82
);
    logic             start;
    logic             seed_load;
    logic [63:0]      seed;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] y_ref;
    logic [OUT_W-1:0] y_dut;
    logic             busy;
    logic             done;
    logic             pass;
    logic             mismatch;
    logic [15:0]      fail_idx;
    logic [OUT_W-1:0] sig_ref;
    logic [OUT_W-1:0] sig_dut;

    modport master (
        input  start, seed_load, seed, y_ref, y_dut,
        output stim, busy, done, pass, mismatch, fail_idx, sig_ref, sig_dut
    );

    modport slave (
        output start, seed_load, seed, y_ref, y_dut,
        input  stim, busy, done, pass, mismatch, fail_idx, sig_ref, sig_dut
    );
endinterface

// File: rtl/equiv_check_harness.sv
// Drives LFSR stimulus to a reference model and a netlist copy, compares the
// two outputs at the end of every hold window and folds them into signatures.
module equiv_check_harness #(
    parameter int IN_W         = 68,
    parameter int OUT_W        = 82,
    parameter int NUM_VEC      = 21,
    parameter int HOLD         = 1,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    equiv_check_if.master bus,
    output logic [1:0]    dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [1:0]       state;
    logic [63:0]      lfsr;
    logic [15:0]      idx;
    logic [HW-1:0]    hold_cnt;
    logic [IN_W-1:0]  stim_q;
    logic             busy_q;
    logic             done_q;
    logic             mism_q;
    logic [15:0]      fidx_q;
    logic [OUT_W-1:0] sig_ref_q;
    logic [OUT_W-1:0] sig_dut_q;

    logic [63:0] lfsr_adv;
    logic [63:0] seed_fix;
    logic [63:0] next_lfsr;
    logic        new_fail;
    logic        last_vec;
    logic        hold_end;

    function automatic logic [IN_W-1:0] replicate(input logic [63:0] v);
        logic [IN_W-1:0] r;
        for (int i = 0; i < IN_W; i++) begin
            r[i] = v[6'(i % 64)];
        end
        return r;
    endfunction

    always_comb begin
        lfsr_adv  = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
        seed_fix  = (bus.seed == 64'd0) ? 64'h1 : bus.seed;
        // Vector 1 uses the seed itself; each later vector retires the previous random one.
        next_lfsr = (idx == 16'd0) ? lfsr : lfsr_adv;
        new_fail  = (bus.y_ref != bus.y_dut) && !mism_q;
        last_vec  = (idx == 16'(NUM_VEC));
        hold_end  = (hold_cnt == HW'(HOLD - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lfsr      <= 64'h1;
            idx       <= 16'd0;
            hold_cnt  <= '0;
            stim_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mism_q    <= 1'b0;
            fidx_q    <= 16'd0;
            sig_ref_q <= '0;
            sig_dut_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.seed_load) lfsr <= seed_fix;
                    if (bus.start) begin
                        state     <= S_RUN;
                        stim_q    <= '0;
                        idx       <= 16'd0;
                        hold_cnt  <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        mism_q    <= 1'b0;
                        fidx_q    <= 16'd0;
                        sig_ref_q <= '0;
                        sig_dut_q <= '0;
                    end
                end
                S_RUN: begin
                    if (!hold_end) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end else begin
                        sig_ref_q <= {sig_ref_q[OUT_W-2:0], sig_ref_q[OUT_W-1]} ^ bus.y_ref;
                        sig_dut_q <= {sig_dut_q[OUT_W-2:0], sig_dut_q[OUT_W-1]} ^ bus.y_dut;
                        if (new_fail) begin
                            mism_q <= 1'b1;
                            fidx_q <= idx;
                        end
                        lfsr <= next_lfsr;
                        if (last_vec || (STOP_ON_FAIL && new_fail)) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            idx      <= idx + 16'd1;
                            hold_cnt <= '0;
                            stim_q   <= replicate(next_lfsr);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.stim     = stim_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = done_q && !mism_q;
    assign bus.mismatch = mism_q;
    assign bus.fail_idx = fidx_q;
    assign bus.sig_ref  = sig_ref_q;
    assign bus.sig_dut  = sig_dut_q;
    assign dbg_state    = state;
endmodule
